// File: rtl/clkdiv_pkg.sv
// Shared constants and config clamping for the multi-channel clock divider.
package clkdiv_pkg;

   localparam int unsigned DEF_DIV_DFLT  = 32'd50_000_000;
   localparam int unsigned DEF_HIGH_DFLT = DEF_DIV_DFLT - DEF_DIV_DFLT / 32'd2;
   localparam int unsigned MIN_DIV       = 32'd2;
   localparam int          CFG_W_MAX     = 64;

   typedef logic [CFG_W_MAX-1:0] cfg_word_t;

   typedef struct packed {
      cfg_word_t div;
      cfg_word_t high;
   } cfg_t;

   // Odd ratios give the spare cycle to the high phase.
   function automatic int unsigned default_high(input int unsigned div);
      return div - div / 32'd2;
   endfunction

   function automatic cfg_t clamp_cfg(input cfg_word_t div, input cfg_word_t high);
      cfg_t c;
      c.div  = (div < cfg_word_t'(MIN_DIV)) ? cfg_word_t'(MIN_DIV) : div;
      c.high = (high > c.div) ? c.div : high;
      return c;
   endfunction

endpackage

// File: rtl/clock_divider_multi_if.sv
// Config/enable bus and divided outputs of clock_divider_multi.
interface clock_divider_multi_if #(
   parameter int CH = 2,
   parameter int W  = 32
);
   localparam int CHW = (CH > 1) ? $clog2(CH) : 1;

   logic [CH-1:0]  en;
   logic           cfg_we;
   logic [CHW-1:0] cfg_ch;
   logic [W-1:0]   cfg_div;
   logic [W-1:0]   cfg_high;
   logic [CH-1:0]  cout;
   logic [CH-1:0]  tick;
   logic [CH-1:0]  cfg_pending;

   modport master (
      output en, cfg_we, cfg_ch, cfg_div, cfg_high,
      input  cout, tick, cfg_pending
   );

   modport slave (
      input  en, cfg_we, cfg_ch, cfg_div, cfg_high,
      output cout, tick, cfg_pending
   );
endinterface

// File: rtl/clkdiv_channel.sv
// One divider channel: counter, active and shadow config, registered cout/tick.
module clkdiv_channel
   import clkdiv_pkg::*;
#(
   parameter int          W       = 32,
   parameter int unsigned DEF_DIV = DEF_DIV_DFLT
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         en_i,
   input  logic         we_i,
   input  logic [W-1:0] div_i,
   input  logic [W-1:0] high_i,
   output logic         cout_o,
   output logic         tick_o,
   output logic         pending_o
);
   localparam logic [W-1:0] RST_DIV  = W'(DEF_DIV);
   localparam logic [W-1:0] RST_HIGH = W'(default_high(DEF_DIV));

   function automatic logic [2*W-1:0] commit_cfg(input logic [W-1:0] d, input logic [W-1:0] h);
      cfg_t c;
      c = clamp_cfg(cfg_word_t'(d), cfg_word_t'(h));
      return {c.div[W-1:0], c.high[W-1:0]};
   endfunction

   logic [W-1:0]   count_q, count_d, div_q, div_d, high_q, high_d;
   logic [W-1:0]   sdiv_q, sdiv_d, shigh_q, shigh_d;
   logic           pend_q, pend_d, cout_q, cout_d, tick_q, tick_d;
   logic [2*W-1:0] imm_cfg_s, sh_cfg_s;
   logic           wrap_s;

   assign imm_cfg_s = commit_cfg(div_i, high_i);
   assign sh_cfg_s  = commit_cfg(sdiv_q, shigh_q);
   assign wrap_s    = (count_q >= (div_q - W'(1)));

   // Outputs are computed from the next count so the flops match the count they accompany.
   always_comb begin
      count_d = count_q;
      div_d   = div_q;
      high_d  = high_q;
      sdiv_d  = sdiv_q;
      shigh_d = shigh_q;
      pend_d  = pend_q;
      cout_d  = cout_q;
      tick_d  = 1'b0;
      if (!en_i) begin
         if (we_i) begin
            count_d         = {W{1'b0}};
            {div_d, high_d} = imm_cfg_s;
            pend_d          = 1'b0;
            cout_d          = (count_d >= (div_d - high_d));
         end else begin
            cout_d = cout_q;
         end
      end else begin
         if (wrap_s) begin
            count_d = {W{1'b0}};
            if (pend_q) begin
               {div_d, high_d} = sh_cfg_s;
               pend_d          = 1'b0;
            end else begin
               pend_d = pend_q;
            end
         end else begin
            count_d = count_q + W'(1);
         end
         // A write on the wrap cycle lands in the shadow for the following boundary.
         if (we_i) begin
            sdiv_d  = div_i;
            shigh_d = high_i;
            pend_d  = 1'b1;
         end else begin
            sdiv_d = sdiv_q;
         end
         cout_d = (count_d >= (div_d - high_d));
         tick_d = (count_d == (div_d - W'(1)));
      end
   end

   // Channel state registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q <= {W{1'b0}};
         div_q   <= RST_DIV;
         high_q  <= RST_HIGH;
         sdiv_q  <= {W{1'b0}};
         shigh_q <= {W{1'b0}};
         pend_q  <= 1'b0;
         cout_q  <= 1'b0;
         tick_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         div_q   <= div_d;
         high_q  <= high_d;
         sdiv_q  <= sdiv_d;
         shigh_q <= shigh_d;
         pend_q  <= pend_d;
         cout_q  <= cout_d;
         tick_q  <= tick_d;
      end
   end

   assign cout_o    = cout_q;
   assign tick_o    = tick_q;
   assign pending_o = pend_q;

endmodule

// File: rtl/clock_divider_multi.sv
// CH independent clock dividers with runtime config applied at period boundaries.
module clock_divider_multi
   import clkdiv_pkg::*;
#(
   parameter int          CH      = 2,
   parameter int          W       = 32,
   parameter int unsigned DEF_DIV = DEF_DIV_DFLT
) (
   input logic                  cin,
   input logic                  rst_n,
   clock_divider_multi_if.slave bus
);
   localparam int CHW = (CH > 1) ? $clog2(CH) : 1;

   logic [CH-1:0] we_s;
   logic [CH-1:0] cout_s;
   logic [CH-1:0] tick_s;
   logic [CH-1:0] pend_s;

   // Channel numbers at or above CH match no strobe, so such writes vanish.
   always_comb begin
      for (int i = 0; i < CH; i++) begin
         we_s[i] = bus.cfg_we && (bus.cfg_ch == CHW'(i));
      end
   end

   for (genvar gi = 0; gi < CH; gi++) begin : g_ch
      clkdiv_channel #(
         .W       (W),
         .DEF_DIV (DEF_DIV)
      ) u_ch (
         .clk_i     (cin),
         .rst_ni    (rst_n),
         .en_i      (bus.en[gi]),
         .we_i      (we_s[gi]),
         .div_i     (bus.cfg_div),
         .high_i    (bus.cfg_high),
         .cout_o    (cout_s[gi]),
         .tick_o    (tick_s[gi]),
         .pending_o (pend_s[gi])
      );
   end

   assign bus.cout        = cout_s;
   assign bus.tick        = tick_s;
   assign bus.cfg_pending = pend_s;

endmodule

// File: tb/tb_clock_divider_multi.sv
// Self-checking bench: directed vector table, corner sequences, random traffic vs a cycle model.
module tb_clock_divider_multi;
   localparam int CH   = 3;
   localparam int W    = 16;
   localparam int DIVD = 10;

   logic cin   = 1'b0;
   logic rst_n = 1'b0;

   clock_divider_multi_if #(.CH(CH), .W(W)) bus ();

   clock_divider_multi #(.CH(CH), .W(W), .DEF_DIV(DIVD)) dut (
      .cin   (cin),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 cin = ~cin;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [CH-1:0] en;
      logic          we;
      logic [1:0]    ch;
      logic [W-1:0]  div;
      logic [W-1:0]  high;
      logic [CH-1:0] cout;
      logic [CH-1:0] tick;
      logic [CH-1:0] pend;
   } vec_t;

   vec_t tbl[$];

   // Model state: position in the period plus active/pending config per channel.
   int unsigned m_cnt[CH], m_div[CH], m_high[CH], m_sdiv[CH], m_shigh[CH];
   bit          m_pend[CH], m_tick[CH];

   function automatic void add(input logic [CH-1:0] en, input logic we, input logic [1:0] ch,
                               input int div, input int high, input logic [CH-1:0] cout,
                               input logic [CH-1:0] tick, input logic [CH-1:0] pend);
      vec_t v;
      v.en = en; v.we = we; v.ch = ch; v.div = W'(div); v.high = W'(high);
      v.cout = cout; v.tick = tick; v.pend = pend;
      tbl.push_back(v);
   endfunction

   task automatic check(input string name, input logic [CH-1:0] act, input logic [CH-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic [CH-1:0] en, input logic we, input logic [1:0] ch,
                        input int div, input int high);
      bus.en       = en;
      bus.cfg_we   = we;
      bus.cfg_ch   = ch;
      bus.cfg_div  = W'(div);
      bus.cfg_high = W'(high);
   endtask

   task automatic model_reset();
      for (int c = 0; c < CH; c++) begin
         m_cnt[c] = 0; m_div[c] = DIVD; m_high[c] = DIVD - DIVD / 2;
         m_sdiv[c] = 0; m_shigh[c] = 0; m_pend[c] = 1'b0; m_tick[c] = 1'b0;
      end
   endtask

   task automatic commit(input int c, input int unsigned d, input int unsigned h);
      m_div[c]  = (d < 2) ? 2 : d;
      m_high[c] = (h > m_div[c]) ? m_div[c] : h;
   endtask

   task automatic model_step();
      for (int c = 0; c < CH; c++) begin
         bit we;
         we = bus.cfg_we && (int'(bus.cfg_ch) == c);
         m_tick[c] = 1'b0;
         if (!bus.en[c]) begin
            if (we) begin
               commit(c, int'(bus.cfg_div), int'(bus.cfg_high));
               m_cnt[c] = 0; m_pend[c] = 1'b0;
            end
         end else begin
            if (m_cnt[c] == m_div[c] - 1) begin
               m_cnt[c] = 0;
               if (m_pend[c]) begin
                  commit(c, m_sdiv[c], m_shigh[c]);
                  m_pend[c] = 1'b0;
               end
            end else begin
               m_cnt[c]++;
            end
            if (we) begin
               m_sdiv[c] = int'(bus.cfg_div); m_shigh[c] = int'(bus.cfg_high); m_pend[c] = 1'b1;
            end
            m_tick[c] = (m_cnt[c] == m_div[c] - 1);
         end
      end
   endtask

   // One clock with model tracking; outputs compared on the falling edge.
   task automatic cycle(input string name);
      logic [CH-1:0] ec, et, ep;
      @(posedge cin);
      model_step();
      @(negedge cin);
      for (int c = 0; c < CH; c++) begin
         ec[c] = (m_cnt[c] >= m_div[c] - m_high[c]);
         et[c] = m_tick[c];
         ep[c] = m_pend[c];
      end
      check({name, ".cout"}, bus.cout, ec);
      check({name, ".tick"}, bus.tick, et);
      check({name, ".pend"}, bus.cfg_pending, ep);
   endtask

   task automatic do_reset();
      bus.cfg_we = 1'b0;
      rst_n = 1'b0;
      @(posedge cin);
      @(negedge cin);
      rst_n = 1'b1;
      model_reset();
   endtask

   initial begin
      logic [2:0] seen;
      int tsum;

      // Default 10-cycle pattern; ch1 rewritten to div=4 high=1 mid-period.
      for (int k = 1; k <= 4; k++) add(3'b111, 1'b0, 2'd0, 0, 0, 3'b000, 3'b000, 3'b000);
      for (int k = 5; k <= 8; k++) add(3'b111, 1'b0, 2'd0, 0, 0, 3'b111, 3'b000, 3'b000);
      add(3'b111, 1'b0, 2'd0, 0, 0, 3'b111, 3'b111, 3'b000);
      add(3'b111, 1'b0, 2'd0, 0, 0, 3'b000, 3'b000, 3'b000);
      add(3'b111, 1'b0, 2'd0, 0, 0, 3'b000, 3'b000, 3'b000);
      add(3'b111, 1'b0, 2'd0, 0, 0, 3'b000, 3'b000, 3'b000);
      add(3'b111, 1'b1, 2'd1, 4, 1, 3'b000, 3'b000, 3'b010);
      add(3'b111, 1'b0, 2'd0, 0, 0, 3'b000, 3'b000, 3'b010);
      for (int k = 15; k <= 18; k++) add(3'b111, 1'b0, 2'd0, 0, 0, 3'b111, 3'b000, 3'b010);
      add(3'b111, 1'b0, 2'd0, 0, 0, 3'b111, 3'b111, 3'b010);
      add(3'b111, 1'b0, 2'd0, 0, 0, 3'b000, 3'b000, 3'b000);
      add(3'b111, 1'b0, 2'd0, 0, 0, 3'b000, 3'b000, 3'b000);
      add(3'b111, 1'b0, 2'd0, 0, 0, 3'b000, 3'b000, 3'b000);
      add(3'b111, 1'b0, 2'd0, 0, 0, 3'b010, 3'b010, 3'b000);
      add(3'b111, 1'b0, 2'd0, 0, 0, 3'b000, 3'b000, 3'b000);
      add(3'b111, 1'b0, 2'd0, 0, 0, 3'b101, 3'b000, 3'b000);
      add(3'b111, 1'b0, 2'd0, 0, 0, 3'b101, 3'b000, 3'b000);
      add(3'b111, 1'b0, 2'd0, 0, 0, 3'b111, 3'b010, 3'b000);

      drive(3'b111, 1'b0, 2'd0, 0, 0);
      @(negedge cin);
      check("reset.cout", bus.cout, 3'b000);
      check("reset.tick", bus.tick, 3'b000);
      check("reset.pend", bus.cfg_pending, 3'b000);
      rst_n = 1'b1;

      foreach (tbl[r]) begin
         drive(tbl[r].en, tbl[r].we, tbl[r].ch, int'(tbl[r].div), int'(tbl[r].high));
         @(posedge cin);
         @(negedge cin);
         check($sformatf("vec%0d.cout", r), bus.cout, tbl[r].cout);
         check($sformatf("vec%0d.tick", r), bus.tick, tbl[r].tick);
         check($sformatf("vec%0d.pend", r), bus.cfg_pending, tbl[r].pend);
      end

      // Clamped write to a disabled channel commits at once.
      do_reset();
      drive(3'b011, 1'b1, 2'd2, 0, 7);
      cycle("clamp_wr");
      check("clamp.cout2", {2'b00, bus.cout[2]}, 3'b001);
      check("clamp.pend2", {2'b00, bus.cfg_pending[2]}, 3'b000);
      drive(3'b111, 1'b0, 2'd0, 0, 0);
      tsum = 0;
      for (int k = 0; k < 6; k++) begin
         cycle("clamp_run");
         tsum += int'(bus.tick[2]);
      end
      check("clamp.ticks", 3'(tsum), 3'd3);

      // Enable drop at count 6: hold, then resume at 7 with the tick three cycles on.
      do_reset();
      drive(3'b111, 1'b0, 2'd0, 0, 0);
      for (int k = 0; k < 6; k++) cycle("hold_pre");
      drive(3'b110, 1'b0, 2'd0, 0, 0);
      tsum = 0;
      for (int k = 0; k < 20; k++) begin
         cycle("hold");
         tsum += int'(bus.tick[0]);
      end
      check("hold.ticks0", 3'(tsum), 3'd0);
      check("hold.cout0", {2'b00, bus.cout[0]}, 3'b001);
      drive(3'b111, 1'b0, 2'd0, 0, 0);
      for (int k = 0; k < 3; k++) begin
         cycle("resume");
         seen[k] = bus.tick[0];
      end
      check("resume.tick0", seen, 3'b100);

      // Two writes before the boundary plus an out-of-range channel.
      do_reset();
      drive(3'b111, 1'b0, 2'd0, 0, 0);
      for (int k = 0; k < 3; k++) cycle("dbl_pre");
      drive(3'b111, 1'b1, 2'd0, 6, 3);
      cycle("dbl_w1");
      drive(3'b111, 1'b1, 2'd3, 5, 5);
      cycle("dbl_oor");
      drive(3'b111, 1'b1, 2'd0, 8, 4);
      cycle("dbl_w2");
      drive(3'b111, 1'b0, 2'd0, 0, 0);
      for (int k = 0; k < 25; k++) cycle("dbl_run");

      // Asynchronous reset with a pending write.
      drive(3'b111, 1'b1, 2'd1, 3, 1);
      cycle("ar_wr");
      drive(3'b111, 1'b0, 2'd0, 0, 0);
      cycle("ar_mid");
      #3 rst_n = 1'b0;
      #1;
      check("async.cout", bus.cout, 3'b000);
      check("async.tick", bus.tick, 3'b000);
      check("async.pend", bus.cfg_pending, 3'b000);
      @(negedge cin);
      rst_n = 1'b1;
      model_reset();
      for (int k = 0; k < 12; k++) cycle("ar_post");

      // Random traffic against the model.
      for (int k = 0; k < 400; k++) begin
         logic [CH-1:0] en;
         for (int c = 0; c < CH; c++) en[c] = ($urandom_range(0, 9) != 0);
         drive(en, ($urandom_range(0, 5) == 0), 2'($urandom_range(0, 3)),
               int'($urandom_range(0, 12)), int'($urandom_range(0, 14)));
         cycle("rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
